// File: rtl/count_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : count_arbiter                                                   |
// | Purpose  : Arbitrates NREQ requesters onto one shared dual 64-bit event    |
// |            counter (En/Slt/Reset). Slt=0 requests issue a single En beat,  |
// |            Slt=1 requests issue BURST_LEN atomic beats so the counter's    |
// |            divide-by-BURST_LEN prescaler advances exactly once per request.|
// |            A counter clear (Clr) is sequenced between grants.              |
// | Options  : define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins),|
// |            otherwise round-robin starting after the last winner.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module count_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ-1:0] ReqSlt,
  input  logic            Clr,
  output logic [NREQ-1:0] Gnt,
  output logic [NREQ-1:0] Ack,
  output logic            ClrAck,
  output logic            CntEn,
  output logic            CntSlt,
  output logic            CntRst,
  output logic            Busy
);

  localparam int c_PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [c_PTR_W-1:0]  r_ptr, w_ptr;
  logic [c_BEAT_W-1:0] r_beat, w_beat;
  logic [NREQ-1:0]     r_gnt, w_gnt;
  logic [NREQ-1:0]     r_ack, w_ack;
  logic                r_clrack, w_clrack;
  logic                r_cnten, w_cnten;
  logic                r_cntslt, w_cntslt;
  logic                r_cntrst, w_cntrst;
  logic                r_busy, w_busy;

  // Winner search: first requester at or after the pointer, wrapping.
  // The fixed-priority build pins the pointer at 0, so the same search
  // degenerates to lowest-index-wins.
  logic               w_found;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W-1:0] w_idx;

  // Scan requesters in priority order starting from the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = c_PTR_W'((int'(r_ptr) + i) % NREQ);
      if (!w_found && Req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from here
  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_beat   = r_beat;
    w_gnt    = '0;
    w_ack    = '0;
    w_clrack = 1'b0;
    w_cnten  = 1'b0;
    w_cntslt = 1'b0;
    w_cntrst = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Clr) begin
          // Clear wins over any pending request; pointer is left alone
          w_state  = S_CLEAR;
          w_cntrst = 1'b1;
          w_clrack = 1'b1;
        end else if (w_found) begin
          w_gnt   = NREQ'(1) << w_win;
          w_cnten = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
          w_ptr   = '0;
`else
          w_ptr   = c_PTR_W'((int'(w_win) + 1) % NREQ);
`endif
          if (ReqSlt[w_win]) begin
            w_state  = S_BURST;
            w_beat   = '0;
            w_cntslt = 1'b1;
            w_ack    = (BURST_LEN == 1) ? (NREQ'(1) << w_win) : '0;
          end else begin
            w_state = S_SINGLE;
            w_ack   = NREQ'(1) << w_win;
          end
        end
      end
      S_SINGLE: begin
        w_state = S_IDLE;
      end
      S_BURST: begin
        if (r_beat == c_LAST_BEAT) begin
          w_state = S_IDLE;
          w_beat  = '0;
        end else begin
          // Burst stays atomic: grant and counter drive held every beat
          w_beat   = r_beat + c_BEAT_W'(1);
          w_gnt    = r_gnt;
          w_cnten  = 1'b1;
          w_cntslt = 1'b1;
          if ((r_beat + c_BEAT_W'(1)) == c_LAST_BEAT) begin
            w_ack = r_gnt;
          end
        end
      end
      S_CLEAR: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_beat   <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_clrack <= 1'b0;
      r_cnten  <= 1'b0;
      r_cntslt <= 1'b0;
      r_cntrst <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_beat   <= w_beat;
      r_gnt    <= w_gnt;
      r_ack    <= w_ack;
      r_clrack <= w_clrack;
      r_cnten  <= w_cnten;
      r_cntslt <= w_cntslt;
      r_cntrst <= w_cntrst;
      r_busy   <= w_busy;
    end
  end

  assign Gnt    = r_gnt;
  assign Ack    = r_ack;
  assign ClrAck = r_clrack;
  assign CntEn  = r_cnten;
  assign CntSlt = r_cntslt;
  assign CntRst = r_cntrst;
  assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_count_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_count_arbiter                                                |
// | Purpose  : Directed self-checking bench for count_arbiter, with a small    |
// |            behavioural model of the shared dual event counter.            |
// |            Expected grant order follows ARB_FIXED_PRIO_EN when defined.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_count_arbiter;

  localparam int NREQ = 4;

  logic            Clk;
  logic            Reset;
  logic [NREQ-1:0] Req;
  logic [NREQ-1:0] ReqSlt;
  logic            Clr;
  logic [NREQ-1:0] Gnt;
  logic [NREQ-1:0] Ack;
  logic            ClrAck;
  logic            CntEn;
  logic            CntSlt;
  logic            CntRst;
  logic            Busy;

  logic [63:0] Output0;
  logic [63:0] Output1;
  logic [1:0]  r_pre;

  int n_total = 0;
  int n_bad   = 0;

  count_arbiter #(.NREQ(NREQ), .BURST_LEN(4)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .ReqSlt (ReqSlt),
    .Clr    (Clr),
    .Gnt    (Gnt),
    .Ack    (Ack),
    .ClrAck (ClrAck),
    .CntEn  (CntEn),
    .CntSlt (CntSlt),
    .CntRst (CntRst),
    .Busy   (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shared counter: Slt=0 bumps Output0 per En, Slt=1 bumps Output1 every 4th En
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Output0 <= '0;
      Output1 <= '0;
      r_pre   <= '0;
    end else if (CntRst) begin
      Output0 <= '0;
      Output1 <= '0;
      r_pre   <= '0;
    end else if (CntEn) begin
      if (!CntSlt) begin
        Output0 <= Output0 + 64'd1;
      end else begin
        r_pre <= r_pre + 2'd1;
        if (r_pre == 2'd3) Output1 <= Output1 + 64'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_exp(input int g);
`ifdef ARB_FIXED_PRIO_EN
    return 4'b0001;
`else
    return 4'b0001 << (g % 4);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Req = '0; ReqSlt = '0; Clr = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_gnt", 64'(Gnt), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_en", 64'(CntEn), 64'h0);
    chk("rst_ack", 64'(Ack), 64'h0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_busy", 64'(Busy), 64'h0);

    // Single bump on counter 0
    Req = 4'b0001; ReqSlt = 4'b0000;
    @(negedge Clk);
    chk("s_gnt", 64'(Gnt), 64'h1);
    chk("s_en", 64'(CntEn), 64'h1);
    chk("s_slt", 64'(CntSlt), 64'h0);
    chk("s_ack", 64'(Ack), 64'h1);
    chk("s_busy", 64'(Busy), 64'h1);
    Req = '0;
    @(negedge Clk);
    chk("s_idle_gnt", 64'(Gnt), 64'h0);
    chk("s_out0", Output0, 64'd1);
    chk("s_out1", Output1, 64'd0);

    // Three bursts on counter 1
    for (int k = 0; k < 3; k++) begin
      Req = 4'b0010; ReqSlt = 4'b0010;
      @(negedge Clk);
      for (int b = 0; b < 4; b++) begin
        chk("b_gnt", 64'(Gnt), 64'h2);
        chk("b_en", 64'(CntEn), 64'h1);
        chk("b_slt", 64'(CntSlt), 64'h1);
        chk("b_ack", 64'(Ack), (b == 3) ? 64'h2 : 64'h0);
        if (b == 3) begin Req = '0; ReqSlt = '0; end
        @(negedge Clk);
      end
      chk("b_idle_busy", 64'(Busy), 64'h0);
      chk("b_out1", Output1, 64'(k + 1));
    end

    // All requesters held: round-robin order from a fresh pointer
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rr_out0_clr", Output0, 64'd0);
    Req = 4'b1111; ReqSlt = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      @(negedge Clk);
      chk("rr_gnt", 64'(Gnt), 64'(rr_exp(g)));
      chk("rr_ack", 64'(Ack), 64'(rr_exp(g)));
      if (g == 4) Req = '0;
      @(negedge Clk);
      chk("rr_gap", 64'(Gnt), 64'h0);
    end
    chk("rr_out0", Output0, 64'd5);

    // Clear raised mid-burst waits for the burst to finish
    Req = 4'b0010; ReqSlt = 4'b0010;
    @(negedge Clk);
    for (int b = 0; b < 4; b++) begin
      chk("cb_gnt", 64'(Gnt), 64'h2);
      chk("cb_ack", 64'(Ack), (b == 3) ? 64'h2 : 64'h0);
      chk("cb_rst", 64'(CntRst), 64'h0);
      if (b == 1) Clr = 1'b1;
      if (b == 3) begin Req = '0; ReqSlt = '0; end
      @(negedge Clk);
    end
    chk("cb_idle_busy", 64'(Busy), 64'h0);
    chk("cb_idle_rst", 64'(CntRst), 64'h0);
    chk("cb_out1", Output1, 64'd1);
    @(negedge Clk);
    chk("cl_rst", 64'(CntRst), 64'h1);
    chk("cl_ack", 64'(ClrAck), 64'h1);
    chk("cl_en", 64'(CntEn), 64'h0);
    chk("cl_gnt", 64'(Gnt), 64'h0);
    chk("cl_busy", 64'(Busy), 64'h1);
    Clr = 1'b0;
    @(negedge Clk);
    chk("cl_done_ack", 64'(ClrAck), 64'h0);
    chk("cl_out0", Output0, 64'd0);
    chk("cl_out1", Output1, 64'd0);

    // Clr and Req together: clear first, grant two cycles later
    Clr = 1'b1; Req = 4'b0100; ReqSlt = 4'b0000;
    @(negedge Clk);
    chk("cp_clrack", 64'(ClrAck), 64'h1);
    chk("cp_gnt0", 64'(Gnt), 64'h0);
    Clr = 1'b0;
    @(negedge Clk);
    chk("cp_gnt1", 64'(Gnt), 64'h0);
    chk("cp_busy1", 64'(Busy), 64'h0);
    @(negedge Clk);
    chk("cp_gnt2", 64'(Gnt), 64'h4);
    chk("cp_ack2", 64'(Ack), 64'h4);
    Req = '0;
    @(negedge Clk);
    chk("cp_out0", Output0, 64'd1);

    // Async reset on beat 2 of a burst, then pointer restarts at 0
    Req = 4'b0010; ReqSlt = 4'b0010;
    repeat (3) @(negedge Clk);
    chk("ar_gnt_b2", 64'(Gnt), 64'h2);
    Reset = 1'b1;
    #1;
    chk("ar_gnt", 64'(Gnt), 64'h0);
    chk("ar_en", 64'(CntEn), 64'h0);
    chk("ar_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    Reset = 1'b0; Req = 4'b1001; ReqSlt = 4'b0000;
    @(negedge Clk);
    chk("ar_ptr0_gnt", 64'(Gnt), 64'h1);
    Req = '0;
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
